// File: rtl/architecture_iot_buttons_in.sv
// Avalon-MM button/switch input port for the IOT bus.
// Each input bit is synchronised, debounced and edge-detected in its own lane.
// The top level holds the shared register file: IRQ mask, W1C edge capture,
// registered read data and the level irq.

module architecture_iot_buttons_in_lane #(
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int EDGE_TYPE       = 1,
    parameter int IDLE_LEVEL      = 1
) (
    input  logic clk,
    input  logic reset_n,
    input  logic in_bit,
    output logic level,
    output logic edge_hit
);
    localparam int              CW   = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0]   TERM = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic            IDLE = (IDLE_LEVEL != 0);

    logic          sync1, sync2;
    logic          level_d;
    logic [CW-1:0] cnt;

    // Two-flop synchroniser; only sync2 is used downstream.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1 <= IDLE;
            sync2 <= IDLE;
        end else begin
            sync1 <= in_bit;
            sync2 <= sync1;
        end
    end

    // Accept a new level only after it has been stable for DEBOUNCE_CYCLES samples;
    // any return to the current level restarts the count.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            level <= IDLE;
            cnt   <= '0;
        end else if (sync2 == level) begin
            cnt <= '0;
        end else if (cnt == TERM) begin
            level <= sync2;
            cnt   <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    // Delayed copy of the debounced level for edge detection; resets to idle
    // so that reset itself never looks like an edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) level_d <= IDLE;
        else          level_d <= level;
    end

    // Select which transition(s) count as an edge.
    always_comb begin
        edge_hit = 1'b0;
        case (EDGE_TYPE)
            0:       edge_hit = level & ~level_d;
            1:       edge_hit = ~level & level_d;
            default: edge_hit = level ^ level_d;
        endcase
    end
endmodule

module architecture_iot_buttons_in #(
    parameter int WIDTH           = 5,
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int EDGE_TYPE       = 1,
    parameter int IDLE_LEVEL      = 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    input  logic [WIDTH-1:0] in_port,
    output logic [31:0]      readdata,
    output logic             irq
);
    logic [WIDTH-1:0] level;
    logic [WIDTH-1:0] edge_hit;
    logic [WIDTH-1:0] irq_mask;
    logic [WIDTH-1:0] edge_capture;
    logic [WIDTH-1:0] clr;
    logic             rd, wr;
    logic             unused_wdata;

    assign rd           = chipselect &&  write_n;
    assign wr           = chipselect && !write_n;
    assign unused_wdata = ^writedata;

    genvar i;
    generate
        for (i = 0; i < WIDTH; i++) begin : g_lane
            architecture_iot_buttons_in_lane #(
                .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
                .EDGE_TYPE      (EDGE_TYPE),
                .IDLE_LEVEL     (IDLE_LEVEL)
            ) u_lane (
                .clk     (clk),
                .reset_n (reset_n),
                .in_bit  (in_port[i]),
                .level   (level[i]),
                .edge_hit(edge_hit[i])
            );
        end
    endgenerate

    // W1C clear mask for the edge-capture register.
    always_comb begin
        clr = '0;
        if (wr && address == 2'd3) clr = writedata[WIDTH-1:0];
    end

    // IRQ mask write.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)                   irq_mask <= '0;
        else if (wr && address == 2'd2) irq_mask <= writedata[WIDTH-1:0];
    end

    // Edge capture: a new edge beats a simultaneous W1C on the same bit.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) edge_capture <= '0;
        else          edge_capture <= (edge_capture & ~clr) | edge_hit;
    end

    // Registered level interrupt.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) irq <= 1'b0;
        else          irq <= |(edge_capture & irq_mask);
    end

    // Read data, one-cycle latency, held between reads; unused bits read 0.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            readdata <= '0;
        end else if (rd) begin
            case (address)
                2'd0:    readdata <= 32'(level);
                2'd2:    readdata <= 32'(irq_mask);
                2'd3:    readdata <= 32'(edge_capture);
                default: readdata <= '0;
            endcase
        end
    end
endmodule

// File: tb/tb_architecture_iot_buttons_in.sv
// Directed bench for architecture_iot_buttons_in (WIDTH=4, DEBOUNCE_CYCLES=4,
// EDGE_TYPE=1 falling, IDLE_LEVEL=1). Expected read data goes through a queue.
module tb_architecture_iot_buttons_in;
    logic        clk = 1'b0;
    logic        reset_n;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [3:0]  in_port;
    logic [31:0] readdata;
    logic        irq;

    int          total = 0;
    int          bad   = 0;
    logic [31:0] exp_q[$];
    logic [31:0] held;

    architecture_iot_buttons_in #(
        .WIDTH(4), .DEBOUNCE_CYCLES(4), .EDGE_TYPE(1), .IDLE_LEVEL(1)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .address   (address),
        .chipselect(chipselect),
        .write_n   (write_n),
        .writedata (writedata),
        .in_port   (in_port),
        .readdata  (readdata),
        .irq       (irq)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int k = 0; k < n; k++) tick();
    endtask

    task automatic do_read(input logic [1:0] a, input logic [31:0] e, input string tag);
        exp_q.push_back(e);
        address    = a;
        chipselect = 1'b1;
        write_n    = 1'b1;
        tick();
        chipselect = 1'b0;
        check(tag, readdata, exp_q.pop_front());
    endtask

    task automatic do_write(input logic [1:0] a, input logic [31:0] d);
        address    = a;
        writedata  = d;
        chipselect = 1'b1;
        write_n    = 1'b0;
        tick();
        chipselect = 1'b0;
        write_n    = 1'b1;
    endtask

    initial begin
        reset_n    = 1'b0;
        address    = 2'd0;
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = '0;
        in_port    = 4'hF;
        ticks(3);
        check("rst_irq", {31'd0, irq}, 32'd0);
        check("rst_readdata", readdata, 32'd0);
        reset_n = 1'b1;
        tick();

        // 1: reset state of all registers
        do_read(2'd0, 32'hF, "t1_data");
        do_read(2'd3, 32'h0, "t1_edgecap");
        do_read(2'd2, 32'h0, "t1_irqmask");
        do_read(2'd1, 32'h0, "t1_reserved");
        do_write(2'd0, 32'h0);
        do_write(2'd1, 32'hF);
        do_read(2'd0, 32'hF, "t1_data_ro");
        held = readdata;
        ticks(3);
        check("t1_hold", readdata, held);

        // 2: bit 0 falls; DATA changes exactly 6 clocks after the input
        in_port = 4'hE;
        ticks(4);
        do_read(2'd3, 32'h0, "t2_edgecap_early");
        do_read(2'd0, 32'hF, "t2_data_clk6_pre");
        do_read(2'd0, 32'hE, "t2_data_clk7");
        do_read(2'd3, 32'h1, "t2_edgecap");
        check("t2_irq_masked", {31'd0, irq}, 32'd0);

        // 3: unmask -> irq; W1C -> irq drops one clock later
        do_write(2'd2, 32'h1);
        tick();
        check("t3_irq_set", {31'd0, irq}, 32'd1);
        do_read(2'd2, 32'h1, "t3_irqmask");
        do_write(2'd3, 32'h1);
        tick();
        check("t3_irq_clr", {31'd0, irq}, 32'd0);
        do_read(2'd3, 32'h0, "t3_edgecap_clr");

        // 4: 3-clock glitch on bit 1 must be rejected
        in_port = 4'hC;
        ticks(3);
        in_port = 4'hE;
        ticks(10);
        do_read(2'd0, 32'hE, "t4_data");
        do_read(2'd3, 32'h0, "t4_edgecap");
        check("t4_irq", {31'd0, irq}, 32'd0);

        // 5: bit 2 edge coincides with W1C of bit 2 -> edge wins
        in_port = 4'hA;
        ticks(6);
        do_write(2'd3, 32'h4);
        do_read(2'd3, 32'h4, "t5_edge_wins");
        do_read(2'd0, 32'hA, "t5_data");
        in_port = 4'hF;
        ticks(12);
        do_read(2'd0, 32'hF, "t5_data_release");
        do_read(2'd3, 32'h4, "t5_no_rise_capture");
        do_write(2'd3, 32'h4);
        do_read(2'd3, 32'h0, "t5_edgecap_clr");

        // 6: reset with pending edges, active irq and a count in progress
        do_write(2'd2, 32'h5);
        in_port = 4'hA;
        ticks(10);
        check("t6_irq_before", {31'd0, irq}, 32'd1);
        do_read(2'd3, 32'h5, "t6_edgecap_before");
        in_port = 4'hF;
        ticks(3);
        #2;
        reset_n = 1'b0;
        #1;
        check("t6_irq_async", {31'd0, irq}, 32'd0);
        check("t6_readdata_async", readdata, 32'd0);
        ticks(2);
        reset_n = 1'b1;
        tick();
        do_read(2'd2, 32'h0, "t6_irqmask");
        do_read(2'd3, 32'h0, "t6_edgecap");
        ticks(10);
        do_read(2'd0, 32'hF, "t6_data");
        do_read(2'd3, 32'h0, "t6_no_edge");
        check("t6_irq_after", {31'd0, irq}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
